capture_ctrl: RTL and testbench
===============================

# capture_ctrl

Frame-level controller for the camera capture path. It arms and gates the `capture` byte-pairing block on frame boundaries, and counts pixels and lines against the configured frame geometry. It detects pixel-FIFO overflow, drops the remainder of a corrupted frame and reports per-frame completion status. It sits in the camera pixel-clock domain, beside `capture`, between the sensor sync signals and the pixel FIFO.

## Interface
- IMG_W, 640, pixels (12-bit words, i.e. `capture` write strobes) per line
- IMG_H, 480, lines per frame
- i_clk  in  1  camera pixel clock, all logic on rising edge
- i_rstn  in  1  synchronous active-low reset
- i_vsync  in  1  sensor VSYNC (active-high pulse marks frame boundary)
- i_href  in  1  sensor HREF (high during active line bytes)
- i_wr  in  1  write strobe from `capture` (`o_wr`), one per pixel
- i_full  in  1  pixel FIFO full
- i_start  in  1  one-cycle request to begin capturing
- i_stop  in  1  one-cycle request to stop at next frame boundary
- i_mode  in  1  0 = single frame, 1 = continuous
- o_cap_en  out  1  enable to `capture`; writes outside it are ignored
- o_busy  out  1  high in any state except IDLE
- o_frame_done  out  1  one-cycle pulse at end of each armed frame
- o_frame_ok  out  1  status qualifying o_frame_done
- o_err  out  2  error code qualifying o_frame_done
- o_line_cnt  out  $clog2(IMG_H+1)  lines completed in current frame
- o_pix_cnt  out  $clog2(IMG_W+1)  pixels in current line

## Operation
- States: IDLE, ARM, SYNC, ACTIVE, DROP.
- IDLE -> ARM on i_start. ARM -> SYNC on vsync rising edge. SYNC -> ACTIVE on vsync falling edge, clearing counters and error.
- ACTIVE: o_pix_cnt += 1 on i_wr. On href falling edge:
  - line_cnt += 1, pix_cnt cleared.
  - If pix_cnt != IMG_W, latch ERR_LINE_LEN.
  - If line_cnt would exceed IMG_H, latch ERR_LINE_CNT.
- Both counters saturate at their maximum value.
- Overflow: i_wr && i_full in ACTIVE latches ERR_OVERFLOW and moves to DROP. DROP ignores i_wr and href.
- Frame end (vsync rising in ACTIVE or DROP):
  - o_frame_done pulses.
  - o_frame_ok = (no error && line_cnt == IMG_H).
  - A short frame with no other error reports ERR_LINE_CNT.
- After frame end: continuous mode with no pending stop -> SYNC; otherwise -> IDLE.
- i_stop:
  - In IDLE/ARM: go to IDLE next cycle.
  - In SYNC/ACTIVE/DROP: latch a pending stop; the next frame end goes to IDLE.
- Error codes: 0 NONE, 1 OVERFLOW, 2 LINE_LEN, 3 LINE_CNT.
- The first error latched wins. If errors coincide, priority is OVERFLOW > LINE_LEN > LINE_CNT.
- Errors are cleared on entry to ACTIVE.

## Timing
- vsync and href are registered once for edge detection. Edges are seen one cycle after the input transition.
- o_cap_en is registered:
  - rises the cycle after the state becomes ACTIVE;
  - falls the cycle after the overflow write or frame-end vsync edge.
- o_frame_done is asserted in the cycle after the vsync rising edge is detected. It is never back-to-back.
- Same-cycle events resolve in this order:
  - An i_wr coincident with an href falling edge is counted in the ending line.
  - Href falling coincident with vsync rising completes the line before the frame is evaluated.
  - i_start in a non-IDLE state is ignored. i_start and i_stop together in IDLE -> stay IDLE.
- Reset values: state IDLE; o_cap_en, o_busy, o_frame_done, o_frame_ok = 0; o_err = 0; counters 0; pending stop cleared.
- Reset mid-frame aborts without a done pulse.

## Configuration
- CAPTURE_CTRL_STATS_EN defined: adds two outputs.
  - o_frames_ok (16 bits): count of good frames.
  - o_frames_bad (16 bits): count of bad frames.
  - Each increments on o_frame_done, wraps at 2^16, and resets to 0.
- CAPTURE_CTRL_STATS_EN undefined: neither port nor its counters exist; all other behaviour is identical.

## Structure
- `capture_pkg` holds:
  - state enum `cap_state_t`;
  - error enum `cap_err_t` (NONE/OVERFLOW/LINE_LEN/LINE_CNT);
  - width constant for the stats counters.
- One sub-module, `sync_edge`: registers a sync input and produces rise/fall pulses. It is instantiated for vsync and href.
- Counters and the FSM live in `capture_ctrl`.

## Test plan
All scenarios use IMG_W=5, IMG_H=5.
- Single mode, i_start, one frame of 5 lines × 5 writes:
  - one o_frame_done with ok=1, err=0;
  - then IDLE, o_busy=0, o_cap_en=0.
- Continuous mode, 3 clean frames:
  - three done pulses, all ok=1;
  - i_stop mid-frame-3 -> IDLE after frame 3's done, with no fourth done.
- i_full held high on the 3rd write of line 2:
  - o_cap_en low the next cycle, DROP;
  - remaining writes and href edges ignored;
  - done with ok=0, err=1.
- Line with 4 writes then href fall:
  - err=2 at frame end even though 5 lines are completed;
  - a 6th line instead gives err=3 with o_line_cnt=5.
- Reset asserted in ACTIVE mid-line:
  - all outputs 0 next cycle, no done pulse;
  - a subsequent i_start captures a clean frame with ok=1.
- With CAPTURE_CTRL_STATS_EN: after the overflow frame plus two clean frames, o_frames_ok=2 and o_frames_bad=1.

Source files
------------

// File: rtl/capture_pkg.sv
// Shared types for the camera capture frame controller: FSM states, error codes,
// statistics width and small error-resolution helpers.
package capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_SYNC   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_DROP   = 3'd4
    } cap_state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_OVERFLOW = 2'd1,
        ERR_LINE_LEN = 2'd2,
        ERR_LINE_CNT = 2'd3
    } cap_err_t;

    localparam int STATS_W = 16;

    // An already-latched error is sticky; otherwise the highest-priority new one wins.
    function automatic cap_err_t err_merge(input cap_err_t held, input logic ovf,
                                           input logic len_bad, input logic cnt_bad);
        cap_err_t r;
        if (held != ERR_NONE)  r = held;
        else if (ovf)          r = ERR_OVERFLOW;
        else if (len_bad)      r = ERR_LINE_LEN;
        else if (cnt_bad)      r = ERR_LINE_CNT;
        else                   r = ERR_NONE;
        return r;
    endfunction

    // A frame that ends short with no other error is reported as a line-count error.
    function automatic cap_err_t frame_err(input cap_err_t e, input logic full_height);
        cap_err_t r;
        if (e != ERR_NONE)      r = e;
        else if (!full_height)  r = ERR_LINE_CNT;
        else                    r = ERR_NONE;
        return r;
    endfunction

endpackage

// File: rtl/capture_ctrl_if.sv
// Sensor sync / pixel strobe / control and status bundle of capture_ctrl.
// Statistics outputs exist only when CAPTURE_CTRL_STATS_EN is defined.
interface capture_ctrl_if #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
);
    localparam int LW = $clog2(IMG_H + 1);
    localparam int PW = $clog2(IMG_W + 1);

    logic          i_vsync;
    logic          i_href;
    logic          i_wr;
    logic          i_full;
    logic          i_start;
    logic          i_stop;
    logic          i_mode;
    logic          o_cap_en;
    logic          o_busy;
    logic          o_frame_done;
    logic          o_frame_ok;
    logic [1:0]    o_err;
    logic [LW-1:0] o_line_cnt;
    logic [PW-1:0] o_pix_cnt;
`ifdef CAPTURE_CTRL_STATS_EN
    logic [capture_pkg::STATS_W-1:0] o_frames_ok;
    logic [capture_pkg::STATS_W-1:0] o_frames_bad;
`endif

    modport master (
        output i_vsync, i_href, i_wr, i_full, i_start, i_stop, i_mode,
`ifdef CAPTURE_CTRL_STATS_EN
        input  o_frames_ok, o_frames_bad,
`endif
        input  o_cap_en, o_busy, o_frame_done, o_frame_ok, o_err, o_line_cnt, o_pix_cnt
    );

    modport slave (
        input  i_vsync, i_href, i_wr, i_full, i_start, i_stop, i_mode,
`ifdef CAPTURE_CTRL_STATS_EN
        output o_frames_ok, o_frames_bad,
`endif
        output o_cap_en, o_busy, o_frame_done, o_frame_ok, o_err, o_line_cnt, o_pix_cnt
    );

endinterface

// File: rtl/capture_ctrl_sync_edge.sv
// sync_edge: samples a sensor sync line once and flags its rising/falling edges
// one cycle after the input transition.
module sync_edge (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_sig,
    output logic o_rise,
    output logic o_fall
);
    logic sig_q;
    logic prev_q;

    // Sample register followed by a one-cycle history register.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            sig_q  <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            sig_q  <= i_sig;
            prev_q <= sig_q;
        end
    end

    assign o_rise = sig_q & ~prev_q;
    assign o_fall = ~sig_q & prev_q;

endmodule

// File: rtl/capture_ctrl.sv
// capture_ctrl: frame-level arm/gate FSM, pixel/line counting and per-frame status.
// Define CAPTURE_CTRL_STATS_EN to add good/bad frame counters.
module capture_ctrl
    import capture_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input logic           i_clk,
    input logic           i_rstn,
    capture_ctrl_if.slave bus
);
    localparam int LW = $clog2(IMG_H + 1);
    localparam int PW = $clog2(IMG_W + 1);
    localparam logic [PW-1:0] PIX_MAX  = PW'(IMG_W);
    localparam logic [LW-1:0] LINE_MAX = LW'(IMG_H);
    localparam logic [PW-1:0] PIX_ONE  = PW'(1);
    localparam logic [LW-1:0] LINE_ONE = LW'(1);

    cap_state_t    state_q, state_d;
    logic [PW-1:0] pix_q, pix_d, pix_inc;
    logic [LW-1:0] line_q, line_d, line_inc;
    cap_err_t      err_q, err_d, err_act, end_err;
    cap_err_t      ferr_q, ferr_d;
    logic          stop_q, stop_d;
    logic          done_q, done_d;
    logic          ok_q, ok_d;
    logic          cap_en_q, busy_q;
    logic          vs_rise, vs_fall, hr_rise, hr_fall;
    logic          ovf, len_bad, cnt_bad, stop_any;
    cap_state_t    end_state;

    sync_edge u_vsync (.i_clk(i_clk), .i_rstn(i_rstn), .i_sig(bus.i_vsync),
                       .o_rise(vs_rise), .o_fall(vs_fall));
    sync_edge u_href  (.i_clk(i_clk), .i_rstn(i_rstn), .i_sig(bus.i_href),
                       .o_rise(hr_rise), .o_fall(hr_fall));

    // A write coincident with href falling is counted into the line being closed.
    assign pix_inc   = (bus.i_wr && (pix_q != PIX_MAX)) ? (pix_q + PIX_ONE) : pix_q;
    assign line_inc  = (line_q != LINE_MAX) ? (line_q + LINE_ONE) : line_q;
    assign ovf       = bus.i_wr & bus.i_full;
    assign len_bad   = hr_fall & (pix_inc != PIX_MAX);
    assign cnt_bad   = hr_fall & (line_q == LINE_MAX);
    assign err_act   = err_merge(err_q, ovf, len_bad, cnt_bad);
    assign stop_any  = stop_q | bus.i_stop;
    assign end_state = (bus.i_mode && !stop_any) ? ST_SYNC : ST_IDLE;

    // Next-state, counter and frame-status logic.
    always_comb begin
        state_d = state_q;
        pix_d   = pix_q;
        line_d  = line_q;
        err_d   = err_q;
        stop_d  = stop_q;
        done_d  = 1'b0;
        ok_d    = ok_q;
        ferr_d  = ferr_q;
        end_err = ERR_NONE;
        case (state_q)
            ST_IDLE: begin
                stop_d = 1'b0;
                if (bus.i_start && !bus.i_stop) state_d = ST_ARM;
                else                            state_d = ST_IDLE;
            end
            ST_ARM: begin
                if (bus.i_stop)   state_d = ST_IDLE;
                else if (vs_rise) state_d = ST_SYNC;
                else              state_d = ST_ARM;
            end
            ST_SYNC: begin
                stop_d = stop_any;
                if (vs_fall) begin
                    state_d = ST_ACTIVE;
                    pix_d   = '0;
                    line_d  = '0;
                    err_d   = ERR_NONE;
                end else begin
                    state_d = ST_SYNC;
                end
            end
            ST_ACTIVE: begin
                stop_d = stop_any;
                pix_d  = hr_fall ? '0 : pix_inc;
                line_d = hr_fall ? line_inc : line_q;
                err_d  = err_act;
                if (vs_rise) begin
                    end_err = frame_err(err_act, line_d == LINE_MAX);
                    done_d  = 1'b1;
                    ferr_d  = end_err;
                    ok_d    = (end_err == ERR_NONE);
                    state_d = end_state;
                    stop_d  = 1'b0;
                end else if (ovf) begin
                    state_d = ST_DROP;
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_DROP: begin
                stop_d = stop_any;
                if (vs_rise) begin
                    end_err = frame_err(err_q, line_q == LINE_MAX);
                    done_d  = 1'b1;
                    ferr_d  = end_err;
                    ok_d    = (end_err == ERR_NONE);
                    state_d = end_state;
                    stop_d  = 1'b0;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q  <= ST_IDLE;
            pix_q    <= '0;
            line_q   <= '0;
            err_q    <= ERR_NONE;
            ferr_q   <= ERR_NONE;
            stop_q   <= 1'b0;
            done_q   <= 1'b0;
            ok_q     <= 1'b0;
            cap_en_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pix_q    <= pix_d;
            line_q   <= line_d;
            err_q    <= err_d;
            ferr_q   <= ferr_d;
            stop_q   <= stop_d;
            done_q   <= done_d;
            ok_q     <= ok_d;
            cap_en_q <= (state_q == ST_ACTIVE) && (state_d == ST_ACTIVE);
            busy_q   <= (state_d != ST_IDLE);
        end
    end

`ifdef CAPTURE_CTRL_STATS_EN
    logic [STATS_W-1:0] frames_ok_q, frames_bad_q;

    // Good/bad frame tallies, updated together with the done pulse.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            frames_ok_q  <= '0;
            frames_bad_q <= '0;
        end else if (done_d && ok_d) begin
            frames_ok_q  <= frames_ok_q + {{(STATS_W-1){1'b0}}, 1'b1};
        end else if (done_d) begin
            frames_bad_q <= frames_bad_q + {{(STATS_W-1){1'b0}}, 1'b1};
        end else begin
            frames_ok_q  <= frames_ok_q;
        end
    end

    assign bus.o_frames_ok  = frames_ok_q;
    assign bus.o_frames_bad = frames_bad_q;
`endif

    assign bus.o_cap_en     = cap_en_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_frame_done = done_q;
    assign bus.o_frame_ok   = ok_q;
    assign bus.o_err        = ferr_q;
    assign bus.o_line_cnt   = line_q;
    assign bus.o_pix_cnt    = pix_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Scoreboard bench for capture_ctrl with a 5x5 frame geometry.
module tb_capture_ctrl;
    localparam int W = 5;
    localparam int H = 5;

    typedef struct packed {
        logic       ok;
        logic [1:0] err;
        logic [2:0] line;
    } exp_t;

    logic clk;
    logic rstn;
    int   n_vec;
    int   n_err;
    exp_t sb[$];

    capture_ctrl_if #(.IMG_W(W), .IMG_H(H)) bus ();
    capture_ctrl #(.IMG_W(W), .IMG_H(H)) dut (.i_clk(clk), .i_rstn(rstn), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expected frame status.
    always @(negedge clk) begin
        if (rstn && bus.o_frame_done === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done=1, expected no pulse");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_ok",   int'(bus.o_frame_ok), int'(e.ok));
                chk("done_err",  int'(bus.o_err),      int'(e.err));
                chk("done_line", int'(bus.o_line_cnt), int'(e.line));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.i_start = 1'b1; tick(1); bus.i_start = 1'b0; tick(1);
    endtask

    task automatic pulse_stop();
        bus.i_stop = 1'b1; tick(1); bus.i_stop = 1'b0;
    endtask

    task automatic vsync_pulse();
        bus.i_vsync = 1'b1; tick(3); bus.i_vsync = 1'b0; tick(4);
    endtask

    task automatic do_line(input int nwr, input int full_at);
        bus.i_href = 1'b1; tick(1);
        for (int i = 0; i < nwr; i++) begin
            bus.i_wr   = 1'b1;
            bus.i_full = (i == full_at);
            tick(1);
            bus.i_wr   = 1'b0;
            bus.i_full = 1'b0;
            if (i == full_at) begin
                chk("cap_en_after_ovf", int'(bus.o_cap_en), 0);
                chk("busy_in_drop", int'(bus.o_busy), 1);
            end
            tick(1);
        end
        bus.i_href = 1'b0; tick(4);
    endtask

    task automatic push(input logic ok, input logic [1:0] err, input logic [2:0] line);
        exp_t e;
        e.ok = ok; e.err = err; e.line = line;
        sb.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_cap_en"}, int'(bus.o_cap_en), 0);
        chk({tag, "_busy"},   int'(bus.o_busy), 0);
        chk({tag, "_done"},   int'(bus.o_frame_done), 0);
        chk({tag, "_ok"},     int'(bus.o_frame_ok), 0);
        chk({tag, "_err"},    int'(bus.o_err), 0);
        chk({tag, "_line"},   int'(bus.o_line_cnt), 0);
        chk({tag, "_pix"},    int'(bus.o_pix_cnt), 0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rstn = 1'b0;
        bus.i_vsync = 1'b0; bus.i_href = 1'b0; bus.i_wr = 1'b0; bus.i_full = 1'b0;
        bus.i_start = 1'b0; bus.i_stop = 1'b0; bus.i_mode = 1'b0;
        tick(3);
        check_all_zero("reset");
        rstn = 1'b1;
        tick(2);

        // Single clean frame
        pulse_start();
        chk("single_busy_armed", int'(bus.o_busy), 1);
        vsync_pulse();
        chk("single_cap_en_active", int'(bus.o_cap_en), 1);
        push(1'b1, 2'd0, 3'd5);
        for (int l = 0; l < H; l++) do_line(W, -1);
        vsync_pulse();
        chk("single_busy_end", int'(bus.o_busy), 0);
        chk("single_cap_en_end", int'(bus.o_cap_en), 0);

        // Continuous, three frames, stop requested during the third
        bus.i_mode = 1'b1;
        pulse_start();
        vsync_pulse();
        for (int f = 0; f < 3; f++) begin
            push(1'b1, 2'd0, 3'd5);
            for (int l = 0; l < H; l++) begin
                do_line(W, -1);
                if (f == 2 && l == 1) pulse_stop();
            end
            vsync_pulse();
            if (f < 2) chk("cont_busy_between", int'(bus.o_busy), 1);
        end
        chk("cont_busy_after_stop", int'(bus.o_busy), 0);
        vsync_pulse();
        do_line(W, -1);
        vsync_pulse();
        bus.i_mode = 1'b0;

        // Short first line, then too many lines, then too few lines
        pulse_start(); vsync_pulse();
        push(1'b0, 2'd2, 3'd5);
        do_line(W - 1, -1);
        for (int l = 1; l < H; l++) do_line(W, -1);
        vsync_pulse();
        pulse_start(); vsync_pulse();
        push(1'b0, 2'd3, 3'd5);
        for (int l = 0; l < H + 1; l++) do_line(W, -1);
        vsync_pulse();
        pulse_start(); vsync_pulse();
        push(1'b0, 2'd3, 3'd3);
        for (int l = 0; l < 3; l++) do_line(W, -1);
        vsync_pulse();

        // Reset in the middle of an active line
        pulse_start(); vsync_pulse();
        do_line(W, -1);
        bus.i_href = 1'b1; tick(2);
        bus.i_wr = 1'b1; tick(1); bus.i_wr = 1'b0; tick(1);
        chk("pre_reset_cap_en", int'(bus.o_cap_en), 1);
        rstn = 1'b0;
        tick(1);
        check_all_zero("midreset");
        bus.i_href = 1'b0;
        rstn = 1'b1;
        tick(3);

        // Clean, overflow, clean after reset
        pulse_start(); vsync_pulse();
        push(1'b1, 2'd0, 3'd5);
        for (int l = 0; l < H; l++) do_line(W, -1);
        vsync_pulse();
        pulse_start(); vsync_pulse();
        push(1'b0, 2'd1, 3'd1);
        do_line(W, -1);
        do_line(W, 2);
        for (int l = 2; l < H; l++) do_line(W, -1);
        vsync_pulse();
        chk("ovf_busy_end", int'(bus.o_busy), 0);
        pulse_start(); vsync_pulse();
        push(1'b1, 2'd0, 3'd5);
        for (int l = 0; l < H; l++) do_line(W, -1);
        vsync_pulse();
`ifdef CAPTURE_CTRL_STATS_EN
        chk("stats_ok",  int'(bus.o_frames_ok), 2);
        chk("stats_bad", int'(bus.o_frames_bad), 1);
`endif

        tick(5);
        chk("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
